mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-port synchronous RAM between the pipeline's IF stage (instruction fetch,
//   read-only) and MEM stage (load/store).
// - Arbitrates per cycle, issues registered RAM commands and tracks in-flight reads so each
//   read returns to its owner.
// - Drives per-stage stall signals for the hazard/stall logic.
// - Sits between the pipeline datapath and the unified instruction/data memory.
// PARAMETERS
// - AW             default 10  address width (word address)
// - DW             default 32  data width
// - RD_LAT         default 1   RAM read latency in cycles after ram_en (legal 1..4)
// - MAX_MEM_STREAK default 3   max consecutive MEM wins while IF waits (legal 1..15)
// PORTS
// - clk         in   1   rising-edge clock
// - rst_n       in   1   synchronous reset, active low
// - if_req      in   1   IF read request
// - if_addr     in   AW  IF address
// - if_kill     in   1   discard all IF reads in flight (taken branch/flush)
// - if_gnt      out  1   IF request accepted this cycle
// - if_rvalid   out  1   if_rdata valid
// - if_rdata    out  DW  instruction word
// - mem_req     in   1   MEM request
// - mem_we      in   1   1=write, 0=read
// - mem_addr    in   AW  MEM address
// - mem_wdata   in   DW  store data
// - mem_gnt     out  1   MEM request accepted this cycle
// - mem_rvalid  out  1   mem_rdata valid (reads only)
// - mem_rdata   out  DW  load data
// - stall_if    out  1   if_req & ~if_gnt
// - stall_mem   out  1   mem_req & ~mem_gnt
// - ram_en      out  1   RAM access strobe (registered)
// - ram_we      out  1   RAM write enable (registered)
// - ram_addr    out  AW  RAM address (registered)
// - ram_wdata   out  DW  RAM write data (registered)
// - ram_rdata   in   DW  RAM read data, valid RD_LAT cycles after ram_en
// BEHAVIOUR
// - Clock and reset: single clock clk; reset is synchronous and active-low on rst_n.
// - Grants: if_gnt/mem_gnt are combinational in the request cycle; at most one is high.
// - Arbitration:
//   - MEM wins on conflict unless streak==MAX_MEM_STREAK; IF then wins.
//   - A lone requester always wins.
// - Streak counter:
//   - +1 on each MEM grant while if_req is denied.
//   - Cleared on any IF grant or any cycle with if_req=0.
//   - Saturates at MAX_MEM_STREAK.
// - Issue: grant in cycle t -> ram_en=1 with the winner's we/addr/wdata in cycle t+1.
//   No grant -> ram_en=0, ram_we=0.
// - Read tracking: RD_LAT+1 deep shift register of {valid, owner} tags, advanced every cycle.
// - Read return: owner's rvalid is high in cycle t+1+RD_LAT. rdata = ram_rdata passthrough.
// - Non-owner rdata holds its last value.
// - Writes occupy the port for one cycle and produce no rvalid.
// - One access per cycle, fully pipelined; back-to-back grants are legal.
// - if_kill: clears the valid bit of every IF tag in flight at that edge. A same-cycle IF grant
//   is still issued but also killed. MEM tags are unaffected.
// - Requests must be held until granted; a dropped request is simply not served.
// - Reset (any time, including mid-operation):
//   - Outputs: gnt/rvalid/stall 0, ram_en/ram_we 0, ram_addr/ram_wdata/if_rdata/mem_rdata 0.
//   - Internal: tags cleared, streak 0.
//   - Reads in flight at reset never return.
// CONFIGURATION
// - ARB_PERF_CNT_EN defined:
//   - Adds outputs conflict_cnt[31:0] (cycles with if_req&mem_req) and if_stall_cnt[31:0]
//     (cycles stall_if=1).
//   - Both reset to 0 and wrap at 2^32.
// - ARB_PERF_CNT_EN undefined: ports and counters absent; arbitration identical.
// TESTING
// - IF-only, RD_LAT=1:
//   - Stimulus: if_req held, addresses 0x10,0x11,0x12.
//   - Response: if_gnt every cycle; if_rvalid from cycle 2 with RAM[0x10..0x12]; stall_if=0.
// - Both stages requesting continuously, MAX_MEM_STREAK=3:
//   - Response: grant pattern M,M,M,I,M,M,M,I.
//   - stall_if high on M cycles; stall_mem high on I cycles.
// - Write then fetch:
//   - Stimulus: MEM write 0x20=0xDEADBEEF, then IF read 0x20.
//   - Response: if_rdata=0xDEADBEEF; no mem_rvalid for the write.
// - Kill:
//   - Stimulus: two IF reads in flight plus one MEM read, then if_kill pulsed 1 cycle.
//   - Response: no if_rvalid for the killed reads; mem_rvalid still arrives on time.
// - Reset mid-operation:
//   - Stimulus: rst_n=0 for 1 cycle with 2 reads in flight.
//   - Response: all outputs 0; no rvalid ever for those reads; arbitration restarts with streak=0.
// - ARB_PERF_CNT_EN defined:
//   - Stimulus: 8 conflict cycles as in the MAX_MEM_STREAK=3 scenario.
//   - Response: conflict_cnt=8, if_stall_cnt=6.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between IF (fetch) and MEM (load/store) with per-owner read return.
// Optional ARB_PERF_CNT_EN adds conflict and IF-stall cycle counters.
module mem_port_arbiter #(
    parameter int AW             = 10,
    parameter int DW             = 32,
    parameter int RD_LAT         = 1,
    parameter int MAX_MEM_STREAK = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_kill,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_gnt,
    output logic          mem_rvalid,
    output logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]   conflict_cnt,
    output logic [31:0]   if_stall_cnt
`endif
);

    logic [3:0]        streak;
    logic              streak_max;
    logic              if_win;
    logic [RD_LAT:0]   vld_pipe;
    logic [RD_LAT:0]   own_pipe;   // 1 = IF owns the read
    logic [DW-1:0]     if_rdata_q;
    logic [DW-1:0]     mem_rdata_q;

    assign streak_max = (streak == 4'(MAX_MEM_STREAK));
    assign if_win     = if_req & (~mem_req | streak_max);

    // Grants are combinational but forced low while reset is asserted.
    assign if_gnt    = rst_n & if_win;
    assign mem_gnt   = rst_n & mem_req & ~if_win;
    assign stall_if  = rst_n & if_req & ~if_gnt;
    assign stall_mem = rst_n & mem_req & ~mem_gnt;

    assign if_rvalid  = rst_n & vld_pipe[RD_LAT] & own_pipe[RD_LAT];
    assign mem_rvalid = rst_n & vld_pipe[RD_LAT] & ~own_pipe[RD_LAT];
    assign if_rdata   = !rst_n ? '0 : (if_rvalid  ? ram_rdata : if_rdata_q);
    assign mem_rdata  = !rst_n ? '0 : (mem_rvalid ? ram_rdata : mem_rdata_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak      <= '0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            vld_pipe    <= '0;
            own_pipe    <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if (!if_req || if_gnt)
                streak <= '0;
            else if (mem_gnt && !streak_max)
                streak <= streak + 4'd1;

            ram_en <= if_gnt | mem_gnt;
            ram_we <= mem_gnt & mem_we;
            if (if_gnt) begin
                ram_addr <= if_addr;
            end else if (mem_gnt) begin
                ram_addr  <= mem_addr;
                ram_wdata <= mem_wdata;
            end

            // A same-cycle IF grant is issued to the RAM but its tag is born dead under kill.
            vld_pipe[0] <= (if_gnt & ~if_kill) | (mem_gnt & ~mem_we);
            own_pipe[0] <= if_gnt;
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1] & ~(if_kill & own_pipe[i-1]);
                own_pipe[i] <= own_pipe[i-1];
            end

            if (if_rvalid)  if_rdata_q  <= ram_rdata;
            if (mem_rvalid) mem_rdata_q <= ram_rdata;
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
            if_stall_cnt <= '0;
        end else begin
            conflict_cnt <= conflict_cnt + 32'(if_req & mem_req);
            if_stall_cnt <= if_stall_cnt + 32'(stall_if);
        end
    end
`endif

endmodule
